fc_irq_arbiter: RTL



---
 rtl/fc_irq_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fc_irq_arbiter.sv
// fc_irq_arbiter
//
// Interrupt arbiter between peripheral event lines and the core interrupt
// port. Edge- or level-triggered requests are captured in a pending
// register. One eligible request (pending and unmasked) is selected, either
// by fixed priority (lowest index wins) or by round-robin. It is then shown
// to the core in two forms at once: an ID request/acknowledge handshake and
// an equivalent one-hot vector.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   irq_lines_i        event lines, synchronous to clk_i
//   irq_mask_i         1 = line takes part in arbitration
//   sw_set_i           software set of pending bits (single-cycle pulses)
//   core_irq_req_o     interrupt request to the core
//   core_irq_id_o      ID of the presented request (0 while request is low)
//   core_irq_x_o       one-hot form of the presented request
//   core_irq_ack_i     core acknowledge pulse
//   core_irq_ack_id_i  ID being acknowledged
//   pending_o          pending register
//   spurious_ack_o     pulse, one cycle after an acknowledge that was invalid
module fc_irq_arbiter #(
    parameter int               N_IRQ     = 32,
    parameter int               ID_WIDTH  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}},
    parameter bit               RR_ARB    = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_IRQ-1:0]    irq_lines_i,
    input  logic [N_IRQ-1:0]    irq_mask_i,
    input  logic [N_IRQ-1:0]    sw_set_i,
    output logic                core_irq_req_o,
    output logic [ID_WIDTH-1:0] core_irq_id_o,
    output logic [N_IRQ-1:0]    core_irq_x_o,
    input  logic                core_irq_ack_i,
    input  logic [ID_WIDTH-1:0] core_irq_ack_id_i,
    output logic [N_IRQ-1:0]    pending_o,
    output logic                spurious_ack_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_IRQ-1:0]    prev_q;
    logic [N_IRQ-1:0]    pending_q;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                spur_q;

    logic [N_IRQ-1:0]    set_vec;
    logic [N_IRQ-1:0]    clr_vec;
    logic [N_IRQ-1:0]    elig;
    logic [N_IRQ-1:0]    id_onehot;
    logic [ID_WIDTH-1:0] fp_id;
    logic [ID_WIDTH-1:0] rr_id;
    logic [ID_WIDTH-1:0] sel_id;
    logic                ack_in_range;
    logic                valid_ack;
    logic                cur_elig;
    int                  rr_best;
    int                  rr_dist;

    // Edge lines fire when they go from low to high; level lines fire while
    // they are high. Software sets are merged in unconditionally.
    always_comb begin
        set_vec = sw_set_i
                | (EDGE_MASK & irq_lines_i & ~prev_q)
                | (~EDGE_MASK & irq_lines_i);
    end

    assign elig = pending_q & irq_mask_i;

    // One-hot decode of the held ID. It is used to clear the pending bit, to
    // check whether the held ID is still eligible, and for the line-vector output.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            id_onehot[i] = (int'(id_q) == i);
        end
    end

    assign cur_elig = |(elig & id_onehot);

    assign ack_in_range = (int'(core_irq_ack_id_i) < N_IRQ);
    assign valid_ack    = core_irq_ack_i && (state_q == REQ) &&
                          (core_irq_ack_id_i == id_q) && ack_in_range;

    assign clr_vec = valid_ack ? id_onehot : '0;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        fp_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                fp_id = ID_WIDTH'(i);
            end
        end
    end

    // Round-robin: the winner is the eligible line whose upward distance from
    // ptr_q, modulo N_IRQ, is smallest.
    always_comb begin
        rr_id   = '0;
        rr_best = N_IRQ;
        rr_dist = 0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (elig[i]) begin
                rr_dist = i - int'(ptr_q);
                if (rr_dist < 0) begin
                    rr_dist = rr_dist + N_IRQ;
                end
                if (rr_dist < rr_best) begin
                    rr_best = rr_dist;
                    rr_id   = ID_WIDTH'(i);
                end
            end
        end
    end

    assign sel_id = RR_ARB ? rr_id : fp_id;

    // Next-state logic. id_q is loaded only on entry to REQ, so the presented
    // ID stays stable even if a higher-priority line becomes eligible.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    id_d    = sel_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An acknowledge wins over a withdrawal in the same cycle.
                if (valid_ack) begin
                    state_d = GAP;
                end else if (!cur_elig) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (|elig) begin
                    id_d    = sel_id;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_ack) begin
            if (int'(id_q) == N_IRQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = ID_WIDTH'(int'(id_q) + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= irq_lines_i;
            // Set wins over clear, so an event arriving with its own
            // acknowledge is not lost.
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            spur_q    <= core_irq_ack_i && !valid_ack;
        end
    end

    assign core_irq_req_o = (state_q == REQ);
    assign core_irq_id_o  = core_irq_req_o ? id_q : '0;
    assign core_irq_x_o   = core_irq_req_o ? id_onehot : '0;
    assign pending_o      = pending_q;
    assign spurious_ack_o = spur_q;

endmodule
